encoder8to3_seq: RTL and testbench



---
 rtl/encoder8to3_seq.sv | 103 ++++++++++
 tb/tb_encoder8to3_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/encoder8to3_seq.sv
// rtl/encoder8to3_seq.sv - sequential 8-to-3 encoder, one index per handshake
// Optional: define ENC8_ONEHOT_STRICT_EN to reject multi-hot vectors.
module encoder8to3_seq #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out,
    output logic       out_last,
    output logic       err
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pend;
    logic [7:0] pend_nxt;
    logic       err_nxt;
    logic       vec_ok;

    function automatic logic [2:0] pick(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

`ifdef ENC8_ONEHOT_STRICT_EN
    assign vec_ok = (popcount(in) == 4'd1);
`else
    assign vec_ok = (in != 8'h00);
`endif

    assign in_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (vec_ok) begin
                        pend_nxt  = in;
                        state_nxt = EMIT;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                // out always mirrors the bit selected from pend, so it names the bit to retire
                if (out_ready) begin
                    pend_nxt = pend & ~(8'b1 << out);
                    if (out_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= 8'h00;
            out       <= 3'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            err       <= err_nxt;
            out_valid <= (state_nxt == EMIT);
            out       <= pick(pend_nxt);
            out_last  <= (popcount(pend_nxt) == 4'd1);
        end
    end

endmodule

// File: tb/tb_encoder8to3_seq.sv
// tb/tb_encoder8to3_seq.sv - randomized self-checking bench for encoder8to3_seq
// Instance 0 uses MSB_FIRST=0, instance 1 uses MSB_FIRST=1.
module tb_encoder8to3_seq;

    localparam int NR = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       in_valid;
    logic [1:0][7:0]  in_v;
    logic [1:0]       out_ready;
    logic [1:0]       in_ready;
    logic [1:0]       out_valid;
    logic [1:0][2:0]  out_s;
    logic [1:0]       out_last;
    logic [1:0]       err;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    encoder8to3_seq #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in(in_v[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(out_s[0]),
        .out_last(out_last[0]), .err(err[0])
    );

    encoder8to3_seq #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in(in_v[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(out_s[1]),
        .out_last(out_last[1]), .err(err[1])
    );

    // Reference: list the set bits in emission order; returns 1 if the vector is rejected
    function automatic bit model(input logic [7:0] v, input int msb);
        int cnt;
        bit rej;
        int i;
        exp_q.delete();
        cnt = 0;
        for (int k = 0; k < 8; k++) if (v[k]) cnt++;
        rej = (cnt == 0);
`ifdef ENC8_ONEHOT_STRICT_EN
        if (cnt > 1) rej = 1'b1;
`endif
        if (!rej) begin
            for (int k = 0; k < 8; k++) begin
                i = (msb != 0) ? 7 - k : k;
                if (v[i]) exp_q.push_back(i);
            end
        end
        return rej;
    endfunction

    // mode: 0 = always ready, 1 = ready pattern 1,0,0,1,0,0..., 2 = random ready
    task automatic send(input int d, input logic [7:0] v, input int mode);
        bit rej;
        bit r;
        int c;
        rej = model(v, d);
        tests++; if (in_ready[d] !== 1'b1) begin fails++; $display("FAIL in_ready_pre d=%0d got %b exp 1", d, in_ready[d]); end
        in_valid[d] = 1'b1;
        in_v[d] = v;
        out_ready[d] = 1'b0;
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_v[d] = 8'($urandom);
        if (rej) begin
            tests++; if (err[d] !== 1'b1) begin fails++; $display("FAIL err_pulse d=%0d v=%h got %b exp 1", d, v, err[d]); end
            tests++; if (out_valid[d] !== 1'b0) begin fails++; $display("FAIL rej_out_valid d=%0d v=%h got %b exp 0", d, v, out_valid[d]); end
            tests++; if (in_ready[d] !== 1'b1) begin fails++; $display("FAIL rej_in_ready d=%0d v=%h got %b exp 1", d, v, in_ready[d]); end
            @(negedge clk);
            tests++; if (err[d] !== 1'b0) begin fails++; $display("FAIL err_clear d=%0d v=%h got %b exp 0", d, v, err[d]); end
        end else begin
            c = 0;
            while (exp_q.size() > 0 && c < NR) begin
                tests++; if (out_valid[d] !== 1'b1) begin fails++; $display("FAIL out_valid d=%0d v=%h got %b exp 1", d, v, out_valid[d]); end
                tests++; if (out_s[d] !== 3'(exp_q[0])) begin fails++; $display("FAIL out_idx d=%0d v=%h got %0d exp %0d", d, v, out_s[d], exp_q[0]); end
                tests++; if (out_last[d] !== (exp_q.size() == 1)) begin fails++; $display("FAIL out_last d=%0d v=%h got %b exp %b", d, v, out_last[d], exp_q.size() == 1); end
                tests++; if (in_ready[d] !== 1'b0 || err[d] !== 1'b0) begin fails++; $display("FAIL emit_flags d=%0d v=%h in_ready=%b err=%b exp 0 0", d, v, in_ready[d], err[d]); end
                case (mode)
                    0: r = 1'b1;
                    1: r = (c % 3 == 0);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                out_ready[d] = r;
                in_valid[d] = 1'($urandom_range(0, 1));
                in_v[d] = 8'($urandom);
                @(negedge clk);
                if (r) void'(exp_q.pop_front());
                c++;
            end
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
            tests++; if (c >= NR) begin fails++; $display("FAIL emit_timeout d=%0d v=%h got %0d cycles exp <%0d", d, v, c, NR); end
            tests++; if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin fails++; $display("FAIL post_last d=%0d v=%h out_valid=%b in_ready=%b exp 0 1", d, v, out_valid[d], in_ready[d]); end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            tests++; if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_s[d] !== 3'd0 || out_last[d] !== 1'b0 || err[d] !== 1'b0) begin
                fails++; $display("FAIL reset_state d=%0d got rdy=%b vld=%b out=%0d last=%b err=%b exp 1 0 0 0 0", d, in_ready[d], out_valid[d], out_s[d], out_last[d], err[d]);
            end
        end
    endtask

    task automatic test_sweep();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) send(d, 8'(1 << i), 0);
    endtask

    task automatic test_pattern();
        send(0, 8'b1010_0100, 0);
        send(1, 8'b1010_0100, 0);
    endtask

    task automatic test_reject();
        for (int d = 0; d < 2; d++) begin
            send(d, 8'h00, 0);
            send(d, 8'h11, 0);
        end
    endtask

    task automatic test_back_to_back_err();
        in_valid[0] = 1'b1;
        in_v[0] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests++; if (err[0] !== 1'b1 || in_ready[0] !== 1'b1) begin fails++; $display("FAIL b2b_err k=%0d err=%b in_ready=%b exp 1 1", k, err[0], in_ready[0]); end
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        tests++; if (err[0] !== 1'b0) begin fails++; $display("FAIL b2b_err_clear got %b exp 0", err[0]); end
    endtask

    task automatic test_stall();
        send(0, 8'hFF, 1);
        send(1, 8'hFF, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) send(n % 2, 8'($urandom), (n % 3 == 0) ? 0 : 2);
    endtask

    task automatic test_reset_mid_emit();
        in_valid[0] = 1'b1;
        in_v[0] = 8'hF0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++; if (out_s[0] !== 3'd6 || out_valid[0] !== 1'b1) begin fails++; $display("FAIL pre_reset out=%0d vld=%b exp 6 1", out_s[0], out_valid[0]); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out_valid[0] !== 1'b0 || out_s[0] !== 3'd0 || err[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            fails++; $display("FAIL async_reset vld=%b out=%0d err=%b rdy=%b exp 0 0 0 1", out_valid[0], out_s[0], err[0], in_ready[0]);
        end
        out_ready[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h08, 0);
    endtask

    initial begin
        in_valid = '0;
        in_v = '0;
        out_ready = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_sweep();
        test_pattern();
        test_reject();
        test_back_to_back_err();
        test_stall();
        test_random();
        test_reset_mid_emit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
